// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide on magnitudes.
// States: IDLE (ready, accepts start) | BUSY (one step per cycle, then finalize) | DONE (done pulse).
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              spec_q, spec_d;
  logic [XLEN-1:0]   spec_res_q, spec_res_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              is_div, sgn_a, sgn_b, div_zero, div_ovf;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     add_sum, rem_sh, rem_new;
  logic              rem_ge;
  logic [2*XLEN-1:0] mul_next, div_next, prod;
  logic [XLEN-1:0]   quo_raw, rem_raw, quo_f, rem_f, fin;

  always_comb begin
    is_div   = op_i[2];
    sgn_a    = src_a_i[XLEN-1] & (is_div ? ~op_i[0] : (op_i[1:0] != 2'b11));
    sgn_b    = src_b_i[XLEN-1] & (is_div ? ~op_i[0] : ~op_i[1]);
    mag_a    = sgn_a ? -src_a_i : src_a_i;
    mag_b    = sgn_b ? -src_b_i : src_b_i;
    div_zero = is_div & (src_b_i == {XLEN{1'b0}});
    div_ovf  = is_div & ~op_i[0] & (src_a_i == {1'b1, {(XLEN-1){1'b0}}})
             & (src_b_i == {XLEN{1'b1}});
  end

  // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : {XLEN{1'b0}})};
    mul_next = {add_sum, acc_q[XLEN-1:1]};
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_ge   = rem_sh >= {1'b0, opnd_q};
    rem_new  = rem_ge ? (rem_sh - {1'b0, opnd_q}) : rem_sh;
    div_next = {rem_new[XLEN-1:0], acc_q[XLEN-2:0], rem_ge};
    prod     = neg_q ? -acc_q : acc_q;
    quo_raw  = acc_q[XLEN-1:0];
    rem_raw  = acc_q[2*XLEN-1:XLEN];
    quo_f    = neg_q ? -quo_raw : quo_raw;
    rem_f    = neg_q ? -rem_raw : rem_raw;
    if (spec_q)
      fin = spec_res_q;
    else if (op_q[2])
      fin = op_q[1] ? rem_f : quo_f;
    else
      fin = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    result_d   = result_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          state_d    = S_BUSY;
          op_d       = op_i;
          opnd_d     = is_div ? mag_b : mag_a;
          acc_d      = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
          cnt_d      = '0;
          neg_d      = (is_div && op_i[1]) ? sgn_a : (sgn_a ^ sgn_b);
          spec_d     = div_zero | div_ovf;
          spec_res_d = div_zero ? (op_i[1] ? src_a_i : {XLEN{1'b1}})
                                : (op_i[1] ? {XLEN{1'b0}} : src_a_i);
        end
      end
      S_BUSY: begin
        // one extra cycle after the last step applies sign fix-up and registers the result
        if (cnt_q == LAST) begin
          result_d = fin;
          state_d  = S_DONE;
        end else begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      result_q   <= result_d;
    end
  end

  assign ready_o  = (state_q == S_IDLE);
  assign done_o   = (state_q == S_DONE) && !flush_i;
  assign result_o = result_q;

endmodule
